// File: rtl/ccd_timing_gen.sv
// CCD/ADC pixel-timing and DAC sample sequencer.
// Generates the analog front-end pin timing (clk/shp/shd/hd/vd/clamp) from
// a phase/pixel/line counter chain and feeds the DAC word from a
// valid/ready sample stream, an internal ramp, or the black level.
module ccd_timing_gen #(
  parameter int DAC_W = 14,
  parameter int PH_W  = 9,
  parameter int PIX_W = 10,
  parameter int LN_W  = 10
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [PH_W-1:0]  cfg_reps,
  input  logic [PIX_W-1:0] cfg_pix,
  input  logic [PIX_W-1:0] cfg_blank,
  input  logic [LN_W-1:0]  cfg_lines,
  input  logic [DAC_W-1:0] cfg_black,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_cont,
  input  logic             start,
  input  logic             stop,
  input  logic [DAC_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_fpga,
  output logic             shp_fpga,
  output logic             shd_fpga,
  output logic             hd_fpga,
  output logic             vd_fpga,
  output logic             clpdm_fpga,
  output logic             clpob_fpga,
  output logic             busy,
  output logic             underrun,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Run configuration, captured on the accepted start
  logic [PH_W-1:0]  reps_q;
  logic [PIX_W:0]   pix_act_q;
  logic [PIX_W:0]   pix_tot_q;
  logic [LN_W-1:0]  lines_q;
  logic [DAC_W-1:0] black_q;
  logic [1:0]       mode_q;
  logic             cont_q;

  // Timing counters and test ramp
  logic [PH_W-1:0]  ph_q;
  logic [PIX_W:0]   pix_q;
  logic [LN_W-1:0]  ln_q;
  logic [DAC_W-1:0] ramp_q;

  // Stage-0 decode of the next pin values
  logic             clk_p0, shp_p0, shd_p0, hd_p0, vd_p0, clp_p0;
  logic [DAC_W-1:0] dac_p0;

  logic             start_ok, running, active, is_ccd, is_ramp;
  logic             ph_last, pix_last, ln_last, line_end;
  logic [PH_W-1:0]  half, quarter, eighth, take_ph;

  // Short pixels would collapse the sub-phase windows, so clamp to 8.
  function automatic logic [PH_W-1:0] clamp_reps(input logic [PH_W-1:0] r);
    return (r < PH_W'(8)) ? PH_W'(8) : r;
  endfunction

  function automatic logic [PIX_W-1:0] nz_pix(input logic [PIX_W-1:0] v);
    return (v == '0) ? PIX_W'(1) : v;
  endfunction

  function automatic logic [LN_W-1:0] nz_lines(input logic [LN_W-1:0] v);
    return (v == '0) ? LN_W'(1) : v;
  endfunction

  assign start_ok = (state_q == S_IDLE) && start;
  assign running  = (state_q != S_IDLE);
  assign busy     = running;

  assign half     = reps_q >> 1;
  assign quarter  = reps_q >> 2;
  assign eighth   = reps_q >> 3;

  assign ph_last  = (ph_q == reps_q - PH_W'(1));
  assign pix_last = (pix_q == pix_tot_q - (PIX_W+1)'(1));
  assign ln_last  = (ln_q == lines_q - LN_W'(1));
  assign line_end = ph_last && pix_last;
  assign active   = (pix_q < pix_act_q);
  assign is_ccd   = (mode_q == 2'd1);
  assign is_ramp  = (mode_q == 2'd2);
  assign take_ph  = is_ccd ? half : '0;

  // Consume strobe is decoded directly from the counters, same cycle as the phase match
  assign s_ready  = running && active && !is_ramp && (ph_q == take_ph);

  // Latch the run configuration when a start is accepted
  always_ff @(posedge sys_clk) begin
    if (start_ok) begin
      reps_q    <= clamp_reps(cfg_reps);
      pix_act_q <= {1'b0, nz_pix(cfg_pix)};
      pix_tot_q <= {1'b0, nz_pix(cfg_pix)} + {1'b0, nz_pix(cfg_blank)};
      lines_q   <= nz_lines(cfg_lines);
      black_q   <= cfg_black;
      mode_q    <= cfg_mode;
      cont_q    <= cfg_cont;
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: stop only takes effect at the end of the current line
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (line_end && ln_last && !cont_q) state_d = S_IDLE;
        else if (stop)                      state_d = S_STOP;
      end
      S_STOP: if (line_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Phase -> pixel -> line counter chain and per-active-pixel ramp
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      pix_q  <= '0;
      ln_q   <= '0;
      ramp_q <= '0;
    end else if (start_ok) begin
      ph_q   <= '0;
      pix_q  <= '0;
      ln_q   <= '0;
      ramp_q <= '0;
    end else if (running) begin
      if (ph_last) begin
        ph_q <= '0;
        if (pix_last) begin
          pix_q <= '0;
          ln_q  <= ln_last ? '0 : ln_q + LN_W'(1);
        end else begin
          pix_q <= pix_q + (PIX_W+1)'(1);
        end
      end else begin
        ph_q <= ph_q + PH_W'(1);
      end
      if (is_ramp && active && (ph_q == '0)) ramp_q <= ramp_q + DAC_W'(1);
    end
  end

  // Decode pin levels and the DAC word from the current counters
  always_comb begin
    clk_p0 = 1'b0;
    shp_p0 = 1'b1;
    shd_p0 = 1'b1;
    hd_p0  = 1'b1;
    vd_p0  = 1'b1;
    clp_p0 = 1'b0;
    dac_p0 = dac_d;
    if (running) begin
      clk_p0 = (ph_q < half);
      shp_p0 = !((ph_q >= eighth) && (ph_q < quarter + eighth));
      shd_p0 = !((ph_q >= half + eighth) && (ph_q < half + quarter + eighth));
      hd_p0  = !(pix_q == pix_act_q);
      vd_p0  = !(!active && ln_last);
      clp_p0 = !active;
      if (!active) begin
        dac_p0 = black_q;
      end else if (is_ramp) begin
        if (ph_q == '0) dac_p0 = ramp_q;
      end else if (s_ready) begin
        dac_p0 = s_valid ? s_data : black_q;
      end else if (is_ccd && (ph_q == '0)) begin
        dac_p0 = black_q;
      end
    end
  end

  // ---- stage boundary p0 -> pins: every output pin is registered ----
  // Register pins, frame-done strobe and sticky underrun flag
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dac_d      <= '0;
      clk_fpga   <= 1'b0;
      shp_fpga   <= 1'b1;
      shd_fpga   <= 1'b1;
      hd_fpga    <= 1'b1;
      vd_fpga    <= 1'b1;
      clpdm_fpga <= 1'b0;
      clpob_fpga <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dac_d      <= dac_p0;
      clk_fpga   <= clk_p0;
      shp_fpga   <= shp_p0;
      shd_fpga   <= shd_p0;
      hd_fpga    <= hd_p0;
      vd_fpga    <= vd_p0;
      clpdm_fpga <= clp_p0;
      clpob_fpga <= clp_p0;
      frame_done <= running && (state_d == S_IDLE);
      if (start_ok)                 underrun <= 1'b0;
      else if (s_ready && !s_valid) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen: pixel timing, line/frame counts,
// underrun, test ramp (including wrap on a narrow-DAC instance),
// continuous run with stop, and edge cases.
module tb_ccd_timing_gen;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [8:0]  cfg_reps;
  logic [9:0]  cfg_pix, cfg_blank, cfg_lines;
  logic [13:0] cfg_black, s_data;
  logic [1:0]  cfg_mode;
  logic        cfg_cont, start, stop, s_valid, start2;
  logic        s_ready, clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga;
  logic        clpdm_fpga, clpob_fpga, busy, underrun, frame_done;
  logic [13:0] dac_d;

  logic        d2_s_ready, d2_clk, d2_shp, d2_shd, d2_hd, d2_vd, d2_clpdm, d2_clpob;
  logic        d2_busy, d2_underrun, d2_frame_done;
  logic [3:0]  d2_dac;

  int total = 0;
  int bad   = 0;

  ccd_timing_gen #(.DAC_W(14), .PH_W(9), .PIX_W(10), .LN_W(10)) dut (
    .sys_clk(sys_clk), .rst(rst), .cfg_reps(cfg_reps), .cfg_pix(cfg_pix),
    .cfg_blank(cfg_blank), .cfg_lines(cfg_lines), .cfg_black(cfg_black),
    .cfg_mode(cfg_mode), .cfg_cont(cfg_cont), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_d(dac_d),
    .clk_fpga(clk_fpga), .shp_fpga(shp_fpga), .shd_fpga(shd_fpga),
    .hd_fpga(hd_fpga), .vd_fpga(vd_fpga), .clpdm_fpga(clpdm_fpga),
    .clpob_fpga(clpob_fpga), .busy(busy), .underrun(underrun),
    .frame_done(frame_done)
  );

  // Narrow-DAC instance so the ramp wrap is reachable in a short run
  ccd_timing_gen #(.DAC_W(4), .PH_W(9), .PIX_W(10), .LN_W(10)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .cfg_reps(9'd8), .cfg_pix(10'd20),
    .cfg_blank(10'd1), .cfg_lines(10'd1), .cfg_black(4'd3),
    .cfg_mode(2'd2), .cfg_cont(1'b0), .start(start2), .stop(1'b0),
    .s_data(4'd0), .s_valid(1'b1), .s_ready(d2_s_ready), .dac_d(d2_dac),
    .clk_fpga(d2_clk), .shp_fpga(d2_shp), .shd_fpga(d2_shd),
    .hd_fpga(d2_hd), .vd_fpga(d2_vd), .clpdm_fpga(d2_clpdm),
    .clpob_fpga(d2_clpob), .busy(d2_busy), .underrun(d2_underrun),
    .frame_done(d2_frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dac"}, 32'(dac_d), 32'd0);
    chk({pfx, "_clk"}, 32'(clk_fpga), 32'd0);
    chk({pfx, "_shp"}, 32'(shp_fpga), 32'd1);
    chk({pfx, "_shd"}, 32'(shd_fpga), 32'd1);
    chk({pfx, "_hd"}, 32'(hd_fpga), 32'd1);
    chk({pfx, "_vd"}, 32'(vd_fpga), 32'd1);
    chk({pfx, "_clpdm"}, 32'(clpdm_fpga), 32'd0);
    chk({pfx, "_clpob"}, 32'(clpob_fpga), 32'd0);
    chk({pfx, "_srdy"}, 32'(s_ready), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_underrun"}, 32'(underrun), 32'd0);
    chk({pfx, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(frame_done), 32'd1);
    tick(1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_strobe_len"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int n_srdy, n_hd, n_vd, n_clp, n_fd, n_ob;
    int p;
    logic [13:0] exp_dac;

    rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0;
    cfg_reps = 9'd16; cfg_pix = 10'd2; cfg_blank = 10'd1; cfg_lines = 10'd1;
    cfg_black = 14'h40; cfg_mode = 2'd1; cfg_cont = 1'b0;
    s_data = 14'h123; s_valid = 1'b1;
    #12;
    chk_reset_vals("rst");
    tick(1);
    rst = 1'b0;
    tick(2);

    // Pixel timing, R=16, CCD mode
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_clk_latency", 32'(clk_fpga), 32'd0);
    for (int j = 0; j < 16; j++) begin
      tick(1);
      chk($sformatf("t1_clk_%0d", j), 32'(clk_fpga), 32'(j < 8));
      chk($sformatf("t1_shp_%0d", j), 32'(shp_fpga), 32'(!(j >= 2 && j < 6)));
      chk($sformatf("t1_shd_%0d", j), 32'(shd_fpga), 32'(!(j >= 10 && j < 14)));
      chk($sformatf("t1_srdy_%0d", j), 32'(s_ready), 32'(j == 7));
      chk($sformatf("t1_dac_%0d", j), 32'(dac_d), (j < 8) ? 32'h40 : 32'h123);
    end
    wait_done("t1_done", 60);

    // Line/frame counts, R=8, 4+2 pixels, 3 lines
    cfg_reps = 9'd8; cfg_pix = 10'd4; cfg_blank = 10'd2; cfg_lines = 10'd3;
    n_srdy = 0; n_hd = 0; n_vd = 0; n_clp = 0; n_fd = 0; n_ob = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      if (s_ready === 1'b1) n_srdy++;
      if (hd_fpga === 1'b0) n_hd++;
      if (vd_fpga === 1'b0) n_vd++;
      if (clpdm_fpga === 1'b1) n_clp++;
      if (frame_done === 1'b1) n_fd++;
      if (clpob_fpga !== clpdm_fpga) n_ob++;
      tick(1);
    end
    chk("t2_srdy_count", 32'(n_srdy), 32'd12);
    chk("t2_hd_low", 32'(n_hd), 32'd24);
    chk("t2_vd_low", 32'(n_vd), 32'd16);
    chk("t2_clpdm_high", 32'(n_clp), 32'd48);
    chk("t2_clpob_eq", 32'(n_ob), 32'd0);
    chk("t2_fdone_count", 32'(n_fd), 32'd1);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // Underrun in plain-ADC mode on pixel 2
    cfg_mode = 2'd0; cfg_blank = 10'd1; cfg_lines = 10'd1;
    cfg_black = 14'h55; s_data = 14'h1AB;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t3_srdy_pix0", 32'(s_ready), 32'd1);
    chk("t3_underrun_init", 32'(underrun), 32'd0);
    tick(1);
    chk("t3_dac_pix0", 32'(dac_d), 32'h1AB);
    tick(15);
    s_valid = 1'b0;
    chk("t3_srdy_pix2", 32'(s_ready), 32'd1);
    tick(1);
    s_valid = 1'b1;
    chk("t3_dac_underrun", 32'(dac_d), 32'h55);
    chk("t3_underrun_set", 32'(underrun), 32'd1);
    tick(8);
    chk("t3_dac_pix3", 32'(dac_d), 32'h1AB);
    chk("t3_underrun_sticky", 32'(underrun), 32'd1);
    tick(8);
    chk("t3_dac_blank", 32'(dac_d), 32'h55);
    chk("t3_clpdm_blank", 32'(clpdm_fpga), 32'd1);
    wait_done("t3_done", 20);
    chk("t3_underrun_idle", 32'(underrun), 32'd1);

    // Test ramp, 5+1 pixels, 2 lines; wrap checked on the 4-bit instance
    cfg_mode = 2'd2; cfg_pix = 10'd5; cfg_lines = 10'd2;
    start = 1'b1; start2 = 1'b1;
    tick(1);
    start = 1'b0; start2 = 1'b0;
    chk("t4_underrun_cleared", 32'(underrun), 32'd0);
    n_srdy = (s_ready === 1'b1) ? 1 : 0;
    for (int c = 2; c <= 140; c++) begin
      tick(1);
      if (s_ready === 1'b1) n_srdy++;
      if ((c - 2) % 8 == 0) begin
        p = (c - 2) / 8;
        if (p <= 11) begin
          if (p < 5)                exp_dac = 14'(p);
          else if (p == 5 || p == 11) exp_dac = 14'h55;
          else                      exp_dac = 14'(p - 1);
          chk($sformatf("t4_ramp_p%0d", p), 32'(dac_d), 32'(exp_dac));
        end
        if (p >= 15 && p <= 17)
          chk($sformatf("t4_wrap_p%0d", p), 32'(d2_dac), 32'(p % 16));
      end
    end
    chk("t4_srdy_never", 32'(n_srdy), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);

    // Continuous run, stray start ignored, stop mid-line 1 of frame 2
    cfg_mode = 2'd0; cfg_pix = 10'd2; cfg_lines = 10'd3; cfg_cont = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int c = 1; c <= 122; c++) begin
      start = (c == 50);
      stop  = (c == 100 || c == 105);
      if (c == 73) begin
        chk("t5_busy_frame_wrap", 32'(busy), 32'd1);
        chk("t5_no_done_frame1", 32'(frame_done), 32'd0);
      end
      if (c == 110) chk("t5_busy_stopping", 32'(busy), 32'd1);
      if (c == 120) begin
        chk("t5_busy_line_end", 32'(busy), 32'd1);
        chk("t5_no_done_early", 32'(frame_done), 32'd0);
      end
      if (c == 121) begin
        chk("t5_idle_after_stop", 32'(busy), 32'd0);
        chk("t5_done_after_stop", 32'(frame_done), 32'd1);
      end
      if (c == 122) chk("t5_done_one_cycle", 32'(frame_done), 32'd0);
      tick(1);
    end
    start = 1'b0; stop = 1'b0; cfg_cont = 1'b0;

    // cfg_reps=3 runs as 8
    cfg_reps = 9'd3; cfg_pix = 10'd1; cfg_lines = 10'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk($sformatf("t6_clk_%0d", j), 32'(clk_fpga), 32'(j < 4));
    end
    tick(7);
    chk("t6_busy_last", 32'(busy), 32'd1);
    tick(1);
    chk("t6_done", 32'(frame_done), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);

    // start+stop together in IDLE starts a run; then reset mid-pixel
    cfg_reps = 9'd8; cfg_lines = 10'd2; cfg_black = 14'h77; s_valid = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("t7_busy_start", 32'(busy), 32'd1);
    tick(16);
    chk("t7_run_not_stop", 32'(busy), 32'd1);
    tick(2);
    chk("t7_pre_clk", 32'(clk_fpga), 32'd1);
    chk("t7_pre_shp", 32'(shp_fpga), 32'd0);
    chk("t7_pre_dac", 32'(dac_d), 32'h77);
    chk("t7_pre_underrun", 32'(underrun), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("t7_async_rst");
    tick(1);
    rst = 1'b0;
    s_valid = 1'b1;
    tick(3);
    chk("t7_stays_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
